// File: rtl/dbus_rx_fifo_responder_pkg.sv
// Shared register map for the receive-FIFO responder: register offsets,
// STATUS/CTRL bit positions and the default window base.
package dbus_rx_fifo_responder_pkg;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } regSel_e;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_IRQEN     = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_IRQEN = 1;

    localparam logic [31:0] DEFAULT_BASE = 32'hFF20_0000;

endpackage

// File: rtl/dbus_rx_fifo_responder_sync_fifo_core.sv
// Circular byte FIFO with occupancy counter; flush overrides push and pop.
// Storage has no reset so it maps onto plain RAM.
module sync_fifo_core #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          pushData,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic              pushOk;
    logic              popOk;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign pushOk = push & ~full & ~flush;
    assign popOk  = pop & ~empty & ~flush;
    assign head   = mem[rdPtr];

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PW'(1);
            if (popOk)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(pushOk) - CW'(popOk);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST_N && pushOk) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/dbus_rx_fifo_responder.sv
// Data-bus slave exposing a receive byte FIFO as a 16-byte MMIO window:
// STATUS / DATA (pop on read) / CTRL (flush, irq enable).
module dbus_rx_fifo_responder
    import dbus_rx_fifo_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE,
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              DwReadEnable,
    input  logic              DwWriteEnable,
    input  logic [3:0]        DwByteEnable,
    input  logic [31:0]       DwAddress,
    input  logic [31:0]       DwWriteData,
    output logic [31:0]       DwReadData,
    output logic              oHit,
    input  logic              iPushValid,
    input  logic [DATA_W-1:0] iPushData,
    output logic              oPushReady,
    output logic              oIRQ
);
    localparam int CW = $clog2(DEPTH) + 1;

    regSel_e           regSel;
    logic              readSel;
    logic              writeSel;
    logic              pop;
    logic              flush;
    logic              ovfClear;
    logic              ovfSet;
    logic              pushOk;
    logic              overflow;
    logic              irqEn;
    logic              irqEnNext;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countNext;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              unusedBits;

    assign oHit     = (DwAddress[31:4] == BASE_ADDR[31:4]);
    assign regSel   = regSel_e'(DwAddress[3:2]);
    assign readSel  = DwReadEnable & oHit;
    assign writeSel = DwWriteEnable & oHit & DwByteEnable[0];

    assign pop      = readSel & (regSel == REG_DATA) & ~empty;
    assign flush    = writeSel & (regSel == REG_CTRL) & DwWriteData[CTRL_FLUSH];
    assign ovfClear = writeSel & (regSel == REG_STATUS) & DwWriteData[ST_OVERFLOW];

    // Producer handshake: a byte transfers on the edge where iPushValid and
    // oPushReady are both high; a valid byte offered while full is dropped
    // and recorded in the sticky overflow flag. A flush discards the offer.
    assign oPushReady = iRST_N & ~full;
    assign pushOk     = iPushValid & ~full;
    assign ovfSet     = iPushValid & full & ~flush;

    assign irqEnNext = (writeSel && regSel == REG_CTRL) ? DwWriteData[CTRL_IRQEN] : irqEn;
    assign countNext = flush ? '0 : count + CW'(pushOk) - CW'(pop);

    sync_fifo_core #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .push     (iPushValid),
        .pop      (pop),
        .flush    (flush),
        .pushData (iPushData),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            overflow <= 1'b0;
            irqEn    <= 1'b0;
            oIRQ     <= 1'b0;
        end else begin
            overflow <= ovfSet | (overflow & ~ovfClear);
            irqEn    <= irqEnNext;
            oIRQ     <= irqEnNext & (countNext != '0);
        end
    end

    always_comb begin
        DwReadData = '0;
        if (readSel) begin
            case (regSel)
                REG_STATUS: begin
                    DwReadData[ST_NONEMPTY]              = ~empty;
                    DwReadData[ST_FULL]                  = full;
                    DwReadData[ST_OVERFLOW]              = overflow;
                    DwReadData[ST_IRQEN]                 = irqEn;
                    DwReadData[ST_COUNT_LSB +: 8]        = 8'(count);
                end
                REG_DATA: begin
                    if (!empty) DwReadData[DATA_W-1:0] = head;
                end
                REG_CTRL: DwReadData[CTRL_IRQEN] = irqEn;
                default:  DwReadData = '0;
            endcase
        end
    end

    assign unusedBits = ^{DwWriteData[31:3], DwByteEnable[3:1], DwAddress[1:0]};

endmodule

// File: tb/tb_dbus_rx_fifo_responder.sv
// Directed bench for dbus_rx_fifo_responder: queue-based reference model,
// per-cycle output compare, and literal register checks along the way.
module tb_dbus_rx_fifo_responder;

    localparam logic [31:0] BASE = 32'hFF20_0000;

    logic        iCLK;
    logic        iRST_N;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;
    logic        oHit;
    logic        iPushValid;
    logic [7:0]  iPushData;
    logic        oPushReady;
    logic        oIRQ;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic       mOvf;
    logic       mIrqEn;
    logic       mIrq;
    logic       modelValid = 1'b0;

    logic       mHit, mWr, mFull, mFlush, mClr, mPop, mPush;
    logic [1:0] mOff;

    dbus_rx_fifo_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (16),
        .DATA_W    (8)
    ) dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .DwReadEnable  (DwReadEnable),
        .DwWriteEnable (DwWriteEnable),
        .DwByteEnable  (DwByteEnable),
        .DwAddress     (DwAddress),
        .DwWriteData   (DwWriteData),
        .DwReadData    (DwReadData),
        .oHit          (oHit),
        .iPushValid    (iPushValid),
        .iPushData     (iPushData),
        .oPushReady    (oPushReady),
        .oIRQ          (oIRQ)
    );

    // Clock / reset
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Register contents as seen by the core during the current cycle
    function automatic logic [31:0] expRead();
        logic [31:0] r;
        r = 32'h0;
        if (DwReadEnable && DwAddress[31:4] == BASE[31:4]) begin
            case (DwAddress[3:2])
                2'd0: r = (32'(exp_q.size()) << 8) | (32'(mIrqEn) << 3) | (32'(mOvf) << 2)
                          | (32'(exp_q.size() == 16) << 1) | 32'(exp_q.size() != 0);
                2'd1: r = (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0;
                2'd2: r = 32'(mIrqEn) << 1;
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    always @(posedge iCLK) begin
        if (!iRST_N) begin
            exp_q.delete();
            mOvf       = 1'b0;
            mIrqEn     = 1'b0;
            mIrq       = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            mHit   = (DwAddress[31:4] == BASE[31:4]);
            mOff   = DwAddress[3:2];
            mWr    = DwWriteEnable && mHit && DwByteEnable[0];
            mFull  = (exp_q.size() == 16);
            mFlush = mWr && mOff == 2'd2 && DwWriteData[0];
            mClr   = mWr && mOff == 2'd0 && DwWriteData[2];
            mPop   = DwReadEnable && mHit && mOff == 2'd1 && exp_q.size() != 0;
            mPush  = iPushValid && !mFull;
            if (mFlush) exp_q.delete();
            else begin
                if (mPop)  void'(exp_q.pop_front());
                if (mPush) exp_q.push_back(iPushData);
            end
            mOvf = (iPushValid && mFull && !mFlush) || (mOvf && !mClr);
            if (mWr && mOff == 2'd2) mIrqEn = DwWriteData[1];
            mIrq = mIrqEn && exp_q.size() != 0;
        end
    end

    // Compare process: every cycle once the model has seen a reset
    always @(negedge iCLK) begin
        if (modelValid) begin
            check("rdata", DwReadData, expRead());
            check("push_ready", 32'(oPushReady), 32'(iRST_N && exp_q.size() != 16));
            check("irq", 32'(oIRQ), 32'(mIrq));
            check("hit", 32'(oHit), 32'(DwAddress[31:4] == BASE[31:4]));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        DwAddress    = addr;
        DwReadEnable = 1'b1;
        @(negedge iCLK);
        data = DwReadData;
        tick();
        DwReadEnable = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        DwAddress     = addr;
        DwWriteData   = wd;
        DwByteEnable  = be;
        DwWriteEnable = 1'b1;
        tick();
        DwWriteEnable = 1'b0;
        DwByteEnable  = 4'h0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        iPushValid = 1'b1;
        iPushData  = b;
        tick();
        iPushValid = 1'b0;
    endtask

    logic [31:0] d;

    initial begin
        iRST_N        = 1'b0;
        DwReadEnable  = 1'b0;
        DwWriteEnable = 1'b0;
        DwByteEnable  = 4'h0;
        DwAddress     = BASE;
        DwWriteData   = 32'h0;
        iPushValid    = 1'b0;
        iPushData     = 8'h0;
        tick();
        tick();
        iRST_N = 1'b1;

        busRead(BASE, d);
        check("reset_status", d, 32'h0);
        check("reset_ready", 32'(oPushReady), 32'h1);
        check("reset_irq", 32'(oIRQ), 32'h0);

        pushByte(8'h41);
        pushByte(8'h42);
        busRead(BASE + 32'h4, d);
        check("data_first", d, 32'h41);
        busRead(BASE + 32'h5, d);
        check("data_second", d, 32'h42);
        busRead(BASE, d);
        check("status_drained", d, 32'h0);

        busRead(BASE + 32'h4, d);
        check("data_empty", d, 32'h0);
        busRead(BASE, d);
        check("status_empty_pop", d, 32'h0);

        for (int i = 0; i < 16; i++) pushByte(8'h10 + 8'(i));
        busRead(BASE, d);
        check("status_full", d, 32'h1003);
        check("ready_full", 32'(oPushReady), 32'h0);
        pushByte(8'hAA);
        busRead(BASE, d);
        check("status_overflow", d, 32'h1007);
        busWrite(BASE, 32'h4, 4'h1);
        busRead(BASE, d);
        check("status_ovf_clear", d, 32'h1003);

        // Pop while full with a push offered in the same cycle
        DwAddress    = BASE + 32'h4;
        DwReadEnable = 1'b1;
        iPushValid   = 1'b1;
        iPushData    = 8'hEE;
        @(negedge iCLK);
        d = DwReadData;
        tick();
        DwReadEnable = 1'b0;
        iPushValid   = 1'b0;
        check("full_pop_data", d, 32'h10);
        busRead(BASE, d);
        check("full_pop_status", d, 32'h0F05);
        busWrite(BASE, 32'h4, 4'h1);
        busRead(BASE + 32'h4, d);
        check("full_pop_order", d, 32'h11);
        busWrite(BASE + 32'h8, 32'h1, 4'h1);
        busRead(BASE, d);
        check("status_flushed", d, 32'h0);

        busRead(32'hFF21_0004, d);
        check("miss_read", d, 32'h0);
        busRead(BASE + 32'hC, d);
        check("rsvd_read", d, 32'h0);

        busWrite(BASE + 32'h8, 32'h2, 4'hE);
        busRead(BASE + 32'h8, d);
        check("ctrl_no_be0", d, 32'h0);
        busWrite(BASE + 32'h8, 32'h2, 4'h1);
        busRead(BASE + 32'h8, d);
        check("ctrl_irqen", d, 32'h2);
        pushByte(8'h55);
        check("irq_after_push", 32'(oIRQ), 32'h1);
        busRead(BASE + 32'h4, d);
        check("irq_data", d, 32'h55);
        check("irq_after_pop", 32'(oIRQ), 32'h0);

        for (int i = 0; i < 5; i++) pushByte(8'h60 + 8'(i));
        busRead(BASE, d);
        check("status_five", d, 32'h0509);
        DwAddress     = BASE + 32'h8;
        DwWriteData   = 32'h3;
        DwByteEnable  = 4'h1;
        DwWriteEnable = 1'b1;
        iPushValid    = 1'b1;
        iPushData     = 8'h77;
        tick();
        DwWriteEnable = 1'b0;
        DwByteEnable  = 4'h0;
        iPushValid    = 1'b0;
        check("flush_push_irq", 32'(oIRQ), 32'h0);
        busRead(BASE, d);
        check("flush_push_status", d, 32'h0008);

        for (int i = 0; i < 7; i++) pushByte(8'h30 + 8'(i));
        check("irq_seven", 32'(oIRQ), 32'h1);
        iRST_N = 1'b0;
        tick();
        check("rst_irq", 32'(oIRQ), 32'h0);
        check("rst_ready", 32'(oPushReady), 32'h0);
        busRead(BASE, d);
        check("rst_status", d, 32'h0);
        iRST_N = 1'b1;
        busRead(BASE + 32'h8, d);
        check("rst_ctrl", d, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
